// File: rtl/fir_seq_ctrl.sv
// Sequencer for a symmetric FIR MAC datapath: deserializes samples, drives tap-pair reads and MAC strobes, saturates results.
// Optional FIR_ROUND_EN: round half-up before the accumulator shift instead of flooring.
module fir_seq_ctrl #(
  parameter int NTAPS   = 16,
  parameter int DW      = 16,
  parameter int ACCW    = 36,
  parameter int SHIFT   = 15,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       filter,
  input  logic                       bit_in,
  input  logic                       bit_vld,
  input  logic                       full,
  input  logic signed [ACCW-1:0]     acc_in,
  output logic                       wr_en,
  output logic [$clog2(NTAPS)-1:0]   wr_addr,
  output logic [DW-1:0]              wr_data,
  output logic [$clog2(NTAPS)-1:0]   rd_addr_a,
  output logic [$clog2(NTAPS)-1:0]   rd_addr_b,
  output logic [$clog2(NTAPS/2)-1:0] coef_addr,
  output logic                       mac_clr,
  output logic                       mac_en,
  output logic                       mac_last,
  output logic [DW-1:0]              dout,
  output logic                       push,
  output logic                       overrun
);

  localparam int AW   = $clog2(NTAPS);
  localparam int CW   = $clog2(NTAPS/2);
  localparam int CNTW = $clog2(NTAPS + MAC_LAT);
  localparam int BITW = $clog2(DW);

  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, CALC, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     newest_q, newest_d;
  logic [DW-2:0]     shreg_q, shreg_d;
  logic [BITW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]     pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              overrun_q, overrun_d;
  logic [DW-1:0]     dout_q, dout_d;

  logic              consume;
  logic [AW-1:0]     k_ext;
  logic signed [ACCW:0] acc_ext;
  logic signed [ACCW:0] acc_sh;
  logic [DW-1:0]     sat_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      head_q     <= '0;
      newest_q   <= '0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      newest_q   <= newest_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      dout_q     <= dout_d;
    end
  end

  assign consume = (state_q == LOAD) && pend_vld_q;
  assign overrun = overrun_q;

  // A sample completing while pend is still held (and not being taken this cycle) is dropped.
  always_comb begin
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    if (state_q == IDLE || state_q == CLR) begin
      bitcnt_d   = '0;
      pend_vld_d = 1'b0;
      if (state_q == CLR) begin
        overrun_d = 1'b0;
      end
    end else begin
      if (consume) begin
        pend_vld_d = 1'b0;
      end
      if (bit_vld) begin
        shreg_d = {shreg_q[DW-3:0], bit_in};
        if (bitcnt_q == BITW'(DW-1)) begin
          bitcnt_d = '0;
          if (pend_vld_q && !consume) begin
            overrun_d = 1'b1;
          end else begin
            pend_d     = {shreg_q, bit_in};
            pend_vld_d = 1'b1;
          end
        end else begin
          bitcnt_d = bitcnt_q + BITW'(1);
        end
      end
    end
  end

  always_comb begin
    acc_ext = {acc_in[ACCW-1], acc_in};
`ifdef FIR_ROUND_EN
    acc_ext = acc_ext + {{(ACCW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
`endif
    acc_sh = acc_ext >>> SHIFT;
    if (acc_sh > SAT_MAX) begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_sh < SAT_MIN) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_val = acc_sh[DW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    newest_d  = newest_q;
    dout_d    = dout_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    coef_addr = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_last  = 1'b0;
    push      = 1'b0;
    k_ext     = AW'(cnt_q[CW-1:0]);
    case (state_q)
      IDLE: begin
        if (filter) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      CLR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q[AW-1:0];
        if (cnt_q == CNTW'(NTAPS-1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      LOAD: begin
        if (pend_vld_q) begin
          wr_en    = 1'b1;
          wr_addr  = head_q;
          wr_data  = pend_q;
          newest_d = head_q;
          head_d   = head_q + AW'(1);
          cnt_d    = '0;
          state_d  = CALC;
        end else if (!filter) begin
          state_d = IDLE;
        end
      end
      // Pair k taps the k-th newest sample against its mirror, the k-th oldest.
      CALC: begin
        rd_addr_a = newest_q - k_ext;
        rd_addr_b = newest_q + AW'(1) + k_ext;
        coef_addr = cnt_q[CW-1:0];
        mac_en    = 1'b1;
        mac_clr   = (cnt_q == '0);
        mac_last  = (cnt_q == CNTW'(NTAPS/2-1));
        if (mac_last) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CNTW'(MAC_LAT-1)) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      OUT: begin
        if (!full) begin
          push    = 1'b1;
          dout_d  = sat_val;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The fresh result is visible during the push cycle and held afterwards.
  assign dout = push ? sat_val : dout_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: random samples and accumulator values against a spec-level model.
module tb_fir_seq_ctrl;

  localparam int NTAPS   = 16;
  localparam int DW      = 16;
  localparam int ACCW    = 36;
  localparam int SHIFT   = 15;
  localparam int MAC_LAT = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   filter;
  logic                   bit_in;
  logic                   bit_vld;
  logic                   full;
  logic signed [ACCW-1:0] acc_in;
  logic                   wr_en;
  logic [3:0]             wr_addr;
  logic [DW-1:0]          wr_data;
  logic [3:0]             rd_addr_a;
  logic [3:0]             rd_addr_b;
  logic [2:0]             coef_addr;
  logic                   mac_clr;
  logic                   mac_en;
  logic                   mac_last;
  logic [DW-1:0]          dout;
  logic                   push;
  logic                   overrun;

  int          checks = 0;
  int          fails  = 0;
  logic        bitq[$];
  bit          gap_en = 1'b0;
  logic [3:0]  head_m = '0;
  logic [15:0] last_dout = '0;
  logic [15:0] ram_img[NTAPS];

  fir_seq_ctrl #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW), .SHIFT(SHIFT), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .filter(filter), .bit_in(bit_in), .bit_vld(bit_vld),
    .full(full), .acc_in(acc_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .coef_addr(coef_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last), .dout(dout),
    .push(push), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Saturated, shifted accumulator value computed with plain integer arithmetic.
  function automatic logic [15:0] expDout(input longint acc);
    longint v, q;
    v = acc;
`ifdef FIR_ROUND_EN
    v = v + 16384;
`endif
    q = v / 32768;
    if (v < 0 && (v % 32768) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic longint randAcc();
    longint r;
    r = longint'($signed($urandom));
    return r >>> $urandom_range(0, 6);
  endfunction

  task automatic queueSample(input logic [15:0] s);
    for (int i = 15; i >= 0; i--) bitq.push_back(s[i]);
  endtask

  // One clock: record RAM writes of the ending cycle, then drive the next serial bit.
  task automatic applyStimulus();
    #1;
    if (wr_en === 1'b1) ram_img[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    if (bitq.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      bit_vld = 1'b1;
      bit_in  = bitq.pop_front();
    end else begin
      bit_vld = 1'b0;
      bit_in  = 1'($urandom);
    end
    #1;
  endtask

  task automatic clearSequence();
    for (int i = 0; i < NTAPS; i++) begin
      applyStimulus();
      checkOutput("clr_wr_en", wr_en, 1);
      checkOutput("clr_wr_addr", wr_addr, i);
      checkOutput("clr_wr_data", wr_data, 0);
    end
    checkOutput("clr_overrun", overrun, 0);
    applyStimulus();
    checkOutput("load_wr_en", wr_en, 0);
  endtask

  task automatic processSample(input logic [15:0] exp_data, input longint acc, input int stall);
    int n;
    logic [3:0] nw;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [15:0] exp_d;
    n = 0;
    while (wr_en !== 1'b1 && n < 80) begin
      applyStimulus();
      n++;
    end
    checkOutput("wr_en", wr_en, 1);
    checkOutput("wr_addr", wr_addr, head_m);
    checkOutput("wr_data", wr_data, exp_data);
    nw     = head_m;
    head_m = head_m + 4'd1;
    acc_in = ACCW'(acc);
    exp_d  = expDout(acc);
    for (int k = 0; k < NTAPS/2; k++) begin
      applyStimulus();
      ea = nw - 4'(k);
      eb = nw + 4'd1 + 4'(k);
      checkOutput("mac_en", mac_en, 1);
      checkOutput("mac_clr", mac_clr, (k == 0));
      checkOutput("mac_last", mac_last, (k == NTAPS/2 - 1));
      checkOutput("rd_addr_a", rd_addr_a, ea);
      checkOutput("rd_addr_b", rd_addr_b, eb);
      checkOutput("coef_addr", coef_addr, k);
    end
    for (int w = 0; w < MAC_LAT; w++) begin
      applyStimulus();
      checkOutput("wait_mac_en", mac_en, 0);
      checkOutput("wait_push", push, 0);
    end
    applyStimulus();
    for (int s = 0; s < stall; s++) begin
      full = 1'b1;
      #1;
      checkOutput("push_stalled", push, 0);
      checkOutput("dout_hold", dout, last_dout);
      applyStimulus();
    end
    full = 1'b0;
    #1;
    checkOutput("push_time", push, 1);
    checkOutput("dout", dout, exp_d);
    last_dout = exp_d;
    applyStimulus();
    checkOutput("push_single", push, 0);
  endtask

  initial begin
    logic [15:0] s1, s2, s3, f;
    int hits;
    int n;

    // Reset held with random inputs: every output must stay low.
    rst_n = 1'b0;
    filter = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; full = 1'b0; acc_in = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      filter = 1'($urandom); bit_in = 1'($urandom); bit_vld = 1'($urandom);
      full = 1'($urandom); acc_in = ACCW'(randAcc());
      #1;
    end
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_rd_addr_a", rd_addr_a, 0);
    checkOutput("rst_rd_addr_b", rd_addr_b, 0);
    checkOutput("rst_coef_addr", coef_addr, 0);
    checkOutput("rst_mac_clr", mac_clr, 0);
    checkOutput("rst_mac_en", mac_en, 0);
    checkOutput("rst_mac_last", mac_last, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_push", push, 0);
    checkOutput("rst_overrun", overrun, 0);

    filter = 1'b0; full = 1'b0; bit_vld = 1'b0; acc_in = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("idle_wr_en", wr_en, 0);
    end
    filter = 1'b1;
    #1;
    clearSequence();

    // Known sample, then the saturation corners, streamed back to back.
    $display("[TB] directed sample and saturation");
    s1 = 16'($urandom); s2 = 16'($urandom); s3 = 16'($urandom);
    queueSample(16'h1234);
    queueSample(s1);
    queueSample(s2);
    queueSample(s3);
    processSample(16'h1234, randAcc(), 0);
    processSample(s1, 64'sd1 <<< 33, 0);
    processSample(s2, -(64'sd1 <<< 33), 0);
    processSample(s3, 64'sd16384, 0);

    $display("[TB] backpressure on output");
    s1 = 16'($urandom);
    queueSample(s1);
    processSample(s1, randAcc(), 5);

    $display("[TB] random samples with bit gaps");
    gap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s1 = 16'($urandom);
      queueSample(s1);
      processSample(s1, randAcc(), $urandom_range(0, 3));
    end
    gap_en = 1'b0;

    // Long stall with a continuous stream: the third sample is lost.
    $display("[TB] overrun");
    s1 = 16'($urandom);
    s2 = 16'($urandom);
    do begin
      s3 = 16'($urandom);
      hits = 0;
      for (int i = 0; i < NTAPS; i++) if (ram_img[i] === s3) hits++;
    end while (hits != 0 || s3 == s1 || s3 == s2);
    queueSample(s1);
    queueSample(s2);
    queueSample(s3);
    processSample(s1, randAcc(), 40);
    checkOutput("overrun_set", overrun, 1);
    processSample(s2, randAcc(), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("overrun_no_write", wr_en, 0);
    end
    hits = 0;
    for (int i = 0; i < NTAPS; i++) if (ram_img[i] === s3) hits++;
    checkOutput("dropped_absent", hits, 0);
    checkOutput("ram_second", ram_img[head_m - 4'd1], s2);
    checkOutput("overrun_sticky", overrun, 1);

    filter = 1'b0;
    #1;
    applyStimulus();
    checkOutput("idle_wr_en2", wr_en, 0);
    filter = 1'b1;
    #1;
    clearSequence();

    // Stop partway through a sample; the stale bits must not leak into the next one.
    $display("[TB] partial sample abort");
    for (int i = 0; i < 7; i++) bitq.push_back(1'($urandom));
    for (int i = 0; i < 7; i++) applyStimulus();
    filter = 1'b0;
    #1;
    applyStimulus();
    checkOutput("abort_wr_en", wr_en, 0);
    checkOutput("abort_push", push, 0);
    filter = 1'b1;
    #1;
    clearSequence();
    f = 16'($urandom);
    queueSample(f);
    processSample(f, randAcc(), 0);

    // Asynchronous reset in the middle of a tap sweep.
    $display("[TB] reset mid-operation");
    f = 16'($urandom);
    queueSample(f);
    n = 0;
    while (wr_en !== 1'b1 && n < 80) begin
      applyStimulus();
      n++;
    end
    checkOutput("mid_wr_en", wr_en, 1);
    applyStimulus();
    checkOutput("mid_mac_en", mac_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_mac_en", mac_en, 0);
    checkOutput("async_mac_clr", mac_clr, 0);
    checkOutput("async_rd_addr_b", rd_addr_b, 0);
    checkOutput("async_wr_en", wr_en, 0);
    checkOutput("async_push", push, 0);
    checkOutput("async_dout", dout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
